bitmanip_unit: RTL and testbench

BITMANIP_UNIT -- requirements
Module: bitmanip_unit

---
 rtl/bitmanip_unit.sv | 215 +++++++++++++++++++++
 tb/tb_bitmanip_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitmanip_unit.sv
// Bit-manipulation unit: logic, compare, byte, rotate, shift-add and sign/zero-extend ops
// finish in one cycle. clz/ctz/cpop walk the operand one byte per cycle with a fixed
// 4-cycle latency.
// Build option: define BITMANIP_ZBS_EN to add single-bit ops bset/bclr/binv/bext (14-17);
// without it those codes report illegal.
module bitmanip_unit (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        bit_valid_i,
   output logic        bit_ready_o,
   input  logic [4:0]  bit_op_i,
   input  logic [31:0] bit_rs1_i,
   input  logic [31:0] bit_rs2_i,
   input  logic        bit_flush_i,
   output logic [31:0] bit_result_o,
   output logic        bit_done_o,
   output logic        bit_illegal_o
);

   localparam logic [4:0] OpAndn   = 5'd0;
   localparam logic [4:0] OpOrn    = 5'd1;
   localparam logic [4:0] OpXnor   = 5'd2;
   localparam logic [4:0] OpClz    = 5'd3;
   localparam logic [4:0] OpCtz    = 5'd4;
   localparam logic [4:0] OpCpop   = 5'd5;
   localparam logic [4:0] OpMax    = 5'd6;
   localparam logic [4:0] OpMaxu   = 5'd7;
   localparam logic [4:0] OpMin    = 5'd8;
   localparam logic [4:0] OpMinu   = 5'd9;
   localparam logic [4:0] OpOrcb   = 5'd10;
   localparam logic [4:0] OpRev8   = 5'd11;
   localparam logic [4:0] OpRol    = 5'd12;
   localparam logic [4:0] OpRor    = 5'd13;
`ifdef BITMANIP_ZBS_EN
   localparam logic [4:0] OpBset   = 5'd14;
   localparam logic [4:0] OpBclr   = 5'd15;
   localparam logic [4:0] OpBinv   = 5'd16;
   localparam logic [4:0] OpBext   = 5'd17;
`endif
   localparam logic [4:0] OpSextB  = 5'd18;
   localparam logic [4:0] OpSextH  = 5'd19;
   localparam logic [4:0] OpZextH  = 5'd20;
   localparam logic [4:0] OpSh1add = 5'd21;
   localparam logic [4:0] OpSh2add = 5'd22;
   localparam logic [4:0] OpSh3add = 5'd23;

   typedef enum logic [0:0] {StIdle, StCount} state_e;
   typedef enum logic [1:0] {KindClz, KindCtz, KindCpop} kind_e;

   state_e      state_q, state_d;
   kind_e       kind_q, kind_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [5:0]  acc_q, acc_d;
   logic        found_q, found_d;
   logic [31:0] src_q, src_d;
   logic [31:0] result_q, result_d;
   logic        done_q, done_d;
   logic        illegal_q, illegal_d;

   logic [31:0] alu_res;
   logic        alu_illegal;
   logic [4:0]  shamt;
   logic [63:0] rol_w, ror_w;
   logic [1:0]  byte_idx;
   logic [7:0]  cur_byte;
   logic [5:0]  acc_next;

   function automatic logic [3:0] lz8(input logic [7:0] b);
      lz8 = 4'd8;
      for (int i = 0; i < 8; i++) if (b[i]) lz8 = 4'(7 - i);
   endfunction

   function automatic logic [3:0] tz8(input logic [7:0] b);
      tz8 = 4'd8;
      for (int i = 7; i >= 0; i--) if (b[i]) tz8 = 4'(i);
   endfunction

   function automatic logic [3:0] pop8(input logic [7:0] b);
      pop8 = 4'd0;
      for (int i = 0; i < 8; i++) pop8 = pop8 + {3'b000, b[i]};
   endfunction

   assign shamt = bit_rs2_i[4:0];
   // Rotates through a doubled operand so a zero amount returns rs1 unchanged.
   assign rol_w = {bit_rs1_i, bit_rs1_i} << shamt;
   assign ror_w = {bit_rs1_i, bit_rs1_i} >> shamt;

   // Single-cycle datapath, evaluated on the request operands.
   always_comb begin
      alu_res     = '0;
      alu_illegal = 1'b0;
      case (bit_op_i)
         OpAndn:   alu_res = bit_rs1_i & ~bit_rs2_i;
         OpOrn:    alu_res = bit_rs1_i | ~bit_rs2_i;
         OpXnor:   alu_res = ~(bit_rs1_i ^ bit_rs2_i);
         OpClz, OpCtz, OpCpop: alu_res = '0;
         OpMax:    alu_res = ($signed(bit_rs1_i) < $signed(bit_rs2_i)) ? bit_rs2_i : bit_rs1_i;
         OpMaxu:   alu_res = (bit_rs1_i < bit_rs2_i) ? bit_rs2_i : bit_rs1_i;
         OpMin:    alu_res = ($signed(bit_rs2_i) < $signed(bit_rs1_i)) ? bit_rs2_i : bit_rs1_i;
         OpMinu:   alu_res = (bit_rs2_i < bit_rs1_i) ? bit_rs2_i : bit_rs1_i;
         OpOrcb: begin
            for (int k = 0; k < 4; k++) alu_res[8*k +: 8] = {8{|bit_rs1_i[8*k +: 8]}};
         end
         OpRev8:   alu_res = {bit_rs1_i[7:0], bit_rs1_i[15:8], bit_rs1_i[23:16],
                              bit_rs1_i[31:24]};
         OpRol:    alu_res = rol_w[63:32];
         OpRor:    alu_res = ror_w[31:0];
`ifdef BITMANIP_ZBS_EN
         OpBset:   alu_res = bit_rs1_i | (32'h1 << shamt);
         OpBclr:   alu_res = bit_rs1_i & ~(32'h1 << shamt);
         OpBinv:   alu_res = bit_rs1_i ^ (32'h1 << shamt);
         OpBext:   alu_res = {31'b0, bit_rs1_i[shamt]};
`endif
         OpSextB:  alu_res = {{24{bit_rs1_i[7]}}, bit_rs1_i[7:0]};
         OpSextH:  alu_res = {{16{bit_rs1_i[15]}}, bit_rs1_i[15:0]};
         OpZextH:  alu_res = {16'b0, bit_rs1_i[15:0]};
         OpSh1add: alu_res = bit_rs2_i + {bit_rs1_i[30:0], 1'b0};
         OpSh2add: alu_res = bit_rs2_i + {bit_rs1_i[29:0], 2'b0};
         OpSh3add: alu_res = bit_rs2_i + {bit_rs1_i[28:0], 3'b0};
         default:  alu_illegal = 1'b1;
      endcase
   end

   // Per-byte step of the counting ops; clz walks from the top byte down.
   always_comb begin
      byte_idx = (kind_q == KindClz) ? ~cnt_q : cnt_q;
      cur_byte = 8'(src_q >> {byte_idx, 3'b000});
      acc_next = acc_q;
      if (kind_q == KindCpop) begin
         acc_next = acc_q + {2'b00, pop8(cur_byte)};
      end else if (!found_q) begin
         acc_next = acc_q + {2'b00, (kind_q == KindClz) ? lz8(cur_byte) : tz8(cur_byte)};
      end
   end

   assign bit_ready_o = (state_q == StIdle);

   // Next-state logic: flush dominates, then request acceptance or count progress.
   always_comb begin
      state_d   = state_q;
      kind_d    = kind_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      found_d   = found_q;
      src_d     = src_q;
      result_d  = result_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      if (bit_flush_i) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bit_valid_i) begin
                  if (bit_op_i == OpClz || bit_op_i == OpCtz || bit_op_i == OpCpop) begin
                     state_d = StCount;
                     cnt_d   = '0;
                     acc_d   = '0;
                     found_d = 1'b0;
                     src_d   = bit_rs1_i;
                     kind_d  = (bit_op_i == OpClz) ? KindClz :
                               (bit_op_i == OpCtz) ? KindCtz : KindCpop;
                  end else begin
                     done_d    = 1'b1;
                     illegal_d = alu_illegal;
                     result_d  = alu_res;
                  end
               end
            end
            StCount: begin
               acc_d   = acc_next;
               cnt_d   = cnt_q + 2'd1;
               found_d = found_q | (|cur_byte);
               if (cnt_q == 2'd3) begin
                  state_d  = StIdle;
                  done_d   = 1'b1;
                  result_d = {26'b0, acc_next};
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         kind_q    <= KindClz;
         cnt_q     <= '0;
         acc_q     <= '0;
         found_q   <= 1'b0;
         src_q     <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         found_q   <= found_d;
         src_q     <= src_d;
         result_q  <= result_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
      end
   end

   assign bit_result_o  = result_q;
   assign bit_done_o    = done_q;
   assign bit_illegal_o = illegal_q;

endmodule

// File: tb/tb_bitmanip_unit.sv
// Self-checking bench for bitmanip_unit: directed vector table, hand-timed multi-cycle
// sequences (count latency, flush, reset), and random ops against a reference model.
// Honours BITMANIP_ZBS_EN the same way as the design.
module tb_bitmanip_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic        ready;
   logic [4:0]  op;
   logic [31:0] rs1, rs2;
   logic        flush;
   logic [31:0] result;
   logic        done;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   bitmanip_unit dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .bit_valid_i  (valid),
      .bit_ready_o  (ready),
      .bit_op_i     (op),
      .bit_rs1_i    (rs1),
      .bit_rs2_i    (rs2),
      .bit_flush_i  (flush),
      .bit_result_o (result),
      .bit_done_o   (done),
      .bit_illegal_o(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ill;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model written from the op definitions, bit by bit.
   function automatic void model(input logic [4:0] o, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] r,
                                 output logic ill);
      int n;
      r   = '0;
      ill = 1'b0;
      n   = 0;
      case (o)
         0:  r = a & ~b;
         1:  r = a | ~b;
         2:  r = ~(a ^ b);
         3: begin
            n = 32;
            for (int i = 0; i < 32; i++) if (a[i]) n = 31 - i;
            r = n;
         end
         4: begin
            n = 32;
            for (int i = 31; i >= 0; i--) if (a[i]) n = i;
            r = n;
         end
         5: begin
            for (int i = 0; i < 32; i++) if (a[i]) n++;
            r = n;
         end
         6:  r = ($signed(a) >= $signed(b)) ? a : b;
         7:  r = (a >= b) ? a : b;
         8:  r = ($signed(a) <= $signed(b)) ? a : b;
         9:  r = (a <= b) ? a : b;
         10: for (int k = 0; k < 4; k++) if (a[8*k +: 8] != 0) r[8*k +: 8] = 8'hFF;
         11: for (int k = 0; k < 4; k++) r[8*k +: 8] = a[8*(3-k) +: 8];
         12: begin
            r = a;
            for (int i = 0; i < int'(b[4:0]); i++) r = {r[30:0], r[31]};
         end
         13: begin
            r = a;
            for (int i = 0; i < int'(b[4:0]); i++) r = {r[0], r[31:1]};
         end
`ifdef BITMANIP_ZBS_EN
         14: begin r = a; r[b[4:0]] = 1'b1; end
         15: begin r = a; r[b[4:0]] = 1'b0; end
         16: begin r = a; r[b[4:0]] = ~a[b[4:0]]; end
         17: r = a[b[4:0]] ? 32'd1 : 32'd0;
`endif
         18: r = 32'($signed(a[7:0]));
         19: r = 32'($signed(a[15:0]));
         20: r = a & 32'h0000FFFF;
         21: r = b + a * 2;
         22: r = b + a * 4;
         23: r = b + a * 8;
         default: ill = 1'b1;
      endcase
   endfunction

   // Present a request at the negedge; returns at the negedge of cycle T+1.
   task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
      valid = 1'b1;
      op    = o;
      rs1   = a;
      rs2   = b;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic do_single(input string name, input logic [4:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] er, input logic ei);
      issue(o, a, b);
      chk({name, ".done"}, {31'b0, done}, 32'd1);
      chk({name, ".illegal"}, {31'b0, illegal}, {31'b0, ei});
      chk({name, ".result"}, result, er);
      chk({name, ".ready"}, {31'b0, ready}, 32'd1);
   endtask

   task automatic do_count(input string name, input logic [4:0] o, input logic [31:0] a,
                           input logic [31:0] er);
      issue(o, a, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("%s.ready_T+%0d", name, i), {31'b0, ready}, 32'd0);
         chk($sformatf("%s.done_T+%0d", name, i), {31'b0, done}, 32'd0);
         @(negedge clk);
      end
      chk({name, ".done_T+5"}, {31'b0, done}, 32'd1);
      chk({name, ".illegal"}, {31'b0, illegal}, 32'd0);
      chk({name, ".result"}, result, er);
      chk({name, ".ready_T+5"}, {31'b0, ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] er, a, b;
      logic        ei;
      logic [4:0]  o;

      valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; flush = 1'b0;
      rst_n = 1'b0;
      #12;
      chk("reset.ready", {31'b0, ready}, 32'd1);
      chk("reset.done", {31'b0, done}, 32'd0);
      chk("reset.illegal", {31'b0, illegal}, 32'd0);
      chk("reset.result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      vecs.push_back('{"ror", 5'd13, 32'h80000001, 32'd1, 32'hC0000000, 1'b0});
      vecs.push_back('{"rol32", 5'd12, 32'h80000001, 32'h20, 32'h80000001, 1'b0});
      vecs.push_back('{"rol0", 5'd12, 32'h12345678, 32'h0, 32'h12345678, 1'b0});
      vecs.push_back('{"min", 5'd8, 32'h80000000, 32'd1, 32'h80000000, 1'b0});
      vecs.push_back('{"minu", 5'd9, 32'h80000000, 32'd1, 32'h00000001, 1'b0});
      vecs.push_back('{"max", 5'd6, 32'h80000000, 32'd1, 32'h00000001, 1'b0});
      vecs.push_back('{"maxu", 5'd7, 32'h80000000, 32'd1, 32'h80000000, 1'b0});
      vecs.push_back('{"andn", 5'd0, 32'hFF, 32'h0F, 32'hF0, 1'b0});
      vecs.push_back('{"orn", 5'd1, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0});
      vecs.push_back('{"xnor", 5'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 1'b0});
      vecs.push_back('{"orcb", 5'd10, 32'h00FF0100, 32'h0, 32'h00FFFF00, 1'b0});
      vecs.push_back('{"rev8", 5'd11, 32'h12345678, 32'h0, 32'h78563412, 1'b0});
      vecs.push_back('{"sextb", 5'd18, 32'h12345680, 32'h0, 32'hFFFFFF80, 1'b0});
      vecs.push_back('{"sexth", 5'd19, 32'h00008000, 32'h0, 32'hFFFF8000, 1'b0});
      vecs.push_back('{"zexth", 5'd20, 32'hABCD1234, 32'h0, 32'h00001234, 1'b0});
      vecs.push_back('{"sh1add", 5'd21, 32'h80000001, 32'd5, 32'h00000007, 1'b0});
      vecs.push_back('{"sh3add", 5'd23, 32'd1, 32'd2, 32'h0000000A, 1'b0});
      vecs.push_back('{"op24", 5'd24, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1});
`ifdef BITMANIP_ZBS_EN
      vecs.push_back('{"bset", 5'd14, 32'h0, 32'd31, 32'h80000000, 1'b0});
      vecs.push_back('{"bext", 5'd17, 32'h00000010, 32'h24, 32'h00000001, 1'b0});
`else
      vecs.push_back('{"bset", 5'd14, 32'h0, 32'd31, 32'h0, 1'b1});
      vecs.push_back('{"bext", 5'd17, 32'h00000010, 32'h24, 32'h0, 1'b1});
`endif
      foreach (vecs[i]) do_single(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                                  vecs[i].res, vecs[i].ill);

      // Result holds with done low on an idle cycle.
      @(negedge clk);
      chk("hold.done", {31'b0, done}, 32'd0);
      chk("hold.result", result, vecs[vecs.size()-1].res);

      do_count("clz0", 5'd3, 32'h0, 32'd32);
      do_count("ctz100", 5'd4, 32'h00000100, 32'd8);
      do_count("cpopF", 5'd5, 32'hFFFFFFFF, 32'd32);
      do_count("clz1", 5'd3, 32'h00010000, 32'd15);
      do_count("ctz0", 5'd4, 32'h0, 32'd32);

      // Back-to-back single-cycle ops, then illegal on the very next cycle.
      issue(5'd23, 32'd1, 32'd2);
      chk("b2b.done1", {31'b0, done}, 32'd1);
      chk("b2b.result1", result, 32'h0000000A);
      issue(5'd31, 32'h5, 32'h6);
      chk("b2b.done2", {31'b0, done}, 32'd1);
      chk("b2b.illegal2", {31'b0, illegal}, 32'd1);
      chk("b2b.result2", result, 32'h0);

      // Flush two cycles into a cpop abandons it.
      issue(5'd5, 32'hFFFFFFFF, 32'h0);
      chk("flush.ready_T+1", {31'b0, ready}, 32'd0);
      @(negedge clk);
      flush = 1'b1;
      chk("flush.done_T+2", {31'b0, done}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      chk("flush.ready_T+3", {31'b0, ready}, 32'd1);
      chk("flush.done_T+3", {31'b0, done}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("flush.nodone", {31'b0, done}, 32'd0);
      end
      do_single("postflush.andn", 5'd0, 32'hFF, 32'h0F, 32'hF0, 1'b0);

      // Flush alongside a request in idle drops the request.
      flush = 1'b1;
      issue(5'd0, 32'hFF, 32'h0);
      flush = 1'b0;
      chk("flushreq.done", {31'b0, done}, 32'd0);
      chk("flushreq.ready", {31'b0, ready}, 32'd1);
      do_count("postflush.clz", 5'd3, 32'h0000FFFF, 32'd16);

      // Reset mid-count gives no done afterwards.
      issue(5'd3, 32'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstcount.ready", {31'b0, ready}, 32'd1);
      chk("rstcount.result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rstcount.nodone", {31'b0, done}, 32'd0);
      end

      // Random ops against the model.
      for (int n = 0; n < 300; n++) begin
         o = 5'($urandom_range(0, 31));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 4))
            0: a = a >> $urandom_range(0, 31);
            1: a = '0;
            2: b = a;
            default: ;
         endcase
         model(o, a, b, er, ei);
         if (o >= 3 && o <= 5) do_count($sformatf("rnd%0d.op%0d", n, o), o, a, er);
         else do_single($sformatf("rnd%0d.op%0d", n, o), o, a, b, er, ei);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
